// File: rtl/usbfs_endp_tx_multi_pkg.sv
// Shared types and constants for the multi-channel bulk IN endpoint block.
// Width helpers derive write-buffer index and packet-length widths.
package usbfs_endp_tx_multi_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } chan_state_e;

  localparam int FLUSH_CYC_1MS = 48000;

  function automatic int wridx_w(input int max_pkt);
    return $clog2(max_pkt);
  endfunction

  function automatic int nbytes_w(input int max_pkt);
    return $clog2(max_pkt + 1);
  endfunction

endpackage

// File: rtl/usbfs_endp_tx_multi_if.sv
// Stream-side and usbfsTxn-side signal bundle for all channels.
// Flattened per-channel buses, channel k at [k*W +: W].
interface usbfs_endp_tx_multi_if
  import usbfs_endp_tx_multi_pkg::*;
#(
  parameter int N_CHAN  = 2,
  parameter int MAX_PKT = 8
);
  localparam int WRIDX_W  = wridx_w(MAX_PKT);
  localparam int NBYTES_W = nbytes_w(MAX_PKT);

  logic [N_CHAN-1:0]          o_ready;
  logic [N_CHAN-1:0]          i_valid;
  logic [N_CHAN*8-1:0]        i_data;
  logic [N_CHAN-1:0]          i_flush;
  logic [N_CHAN-1:0]          i_etReady;
  logic [N_CHAN-1:0]          o_etValid;
  logic [N_CHAN-1:0]          o_etStall;
  logic [N_CHAN-1:0]          o_etWrEn;
  logic [N_CHAN*WRIDX_W-1:0]  o_etWrIdx;
  logic [N_CHAN*8-1:0]        o_etWrByte;
  logic [N_CHAN*NBYTES_W-1:0] o_etWrNBytes;

  modport slave (
    output o_ready,
    input  i_valid,
    input  i_data,
    input  i_flush,
    input  i_etReady,
    output o_etValid,
    output o_etStall,
    output o_etWrEn,
    output o_etWrIdx,
    output o_etWrByte,
    output o_etWrNBytes
  );

  modport master (
    input  o_ready,
    output i_valid,
    output i_data,
    output i_flush,
    output i_etReady,
    input  o_etValid,
    input  o_etStall,
    input  o_etWrEn,
    input  o_etWrIdx,
    input  o_etWrByte,
    input  o_etWrNBytes
  );

endinterface

// File: rtl/usbfs_endp_tx_multi_chan.sv
// One bulk IN channel: byte FIFO, packet packer FSM and idle timer.
// Presents on full packet, idle timeout or flush; ZLP after a full packet.
module usbfs_endp_tx_chan
  import usbfs_endp_tx_multi_pkg::*;
#(
  parameter int MAX_PKT   = 8,
  parameter int DEPTH     = 16,
  parameter int FLUSH_CYC = FLUSH_CYC_1MS,
  parameter int WRIDX_W   = wridx_w(MAX_PKT),
  parameter int NBYTES_W  = nbytes_w(MAX_PKT)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                valid,
  input  logic [7:0]          data,
  input  logic                flush,
  input  logic                et_ready,
  output logic                et_valid,
  output logic                wr_en,
  output logic [WRIDX_W-1:0]  wr_idx,
  output logic [7:0]          wr_byte,
  output logic [NBYTES_W-1:0] wr_nbytes
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(FLUSH_CYC + 1);

  logic [7:0]          mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         fill;
  logic                empty;
  logic                push;
  logic                pop;
  logic                go_present;
  logic                consume;
  logic                timeout;
  logic                kick;
  logic [NBYTES_W-1:0] count;
  logic [TW-1:0]       timer;
  logic                zlp_pend;
  chan_state_e         state;
  chan_state_e         state_nxt;

  assign fill      = wr_ptr - rd_ptr;
  assign empty     = (fill == '0);
  assign ready     = !fill[AW];
  assign push      = valid && ready;
  assign timeout   = (timer == TW'(FLUSH_CYC));
  assign kick      = timeout || flush;
  assign et_valid  = (state == PRESENT);
  assign wr_nbytes = count;

  // FIFO storage; contents are invalidated by the pointer reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  // FIFO pointers, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state, pop and consume decisions; presenting freezes the buffer
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    go_present = 1'b0;
    consume    = 1'b0;
    unique case (state)
      FILL: begin
        if (count == NBYTES_W'(MAX_PKT))
          go_present = 1'b1;
        else if (count != '0 && kick)
          go_present = 1'b1;
        else if (zlp_pend && empty && kick)
          go_present = 1'b1;
        pop = !go_present && !empty &&
              (count < NBYTES_W'(MAX_PKT));
        if (go_present) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (et_ready) begin
          consume   = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Write-buffer strobe, packet length, ZLP flag and idle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_idx   <= '0;
      wr_byte  <= '0;
      count    <= '0;
      zlp_pend <= 1'b0;
      timer    <= '0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        wr_idx  <= count[WRIDX_W-1:0];
        wr_byte <= mem[rd_ptr[AW-1:0]];
        count   <= count + 1'b1;
      end
      if (consume) begin
        zlp_pend <= (count == NBYTES_W'(MAX_PKT));
        count    <= '0;
        timer    <= '0;
      end else if (state == FILL) begin
        if (pop || (count == '0 && !zlp_pend))
          timer <= '0;
        else if (!timeout)
          timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usbfs_endp_tx_multi.sv
// N_CHAN independent bulk IN endpoints feeding usbfsTxn write buffers.
// Each channel is a self-contained usbfs_endp_tx_chan slice.
module usbfs_endp_tx_multi
  import usbfs_endp_tx_multi_pkg::*;
#(
  parameter int N_CHAN    = 2,
  parameter int MAX_PKT   = 8,
  parameter int DEPTH     = 16,
  parameter int FLUSH_CYC = FLUSH_CYC_1MS
) (
  input  logic                i_clk_48MHz,
  input  logic                i_rst,
  usbfs_endp_tx_multi_if.slave bus
);

  localparam int WRIDX_W  = wridx_w(MAX_PKT);
  localparam int NBYTES_W = nbytes_w(MAX_PKT);

  assign bus.o_etStall = '0;

  for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
    usbfs_endp_tx_chan #(
      .MAX_PKT  (MAX_PKT),
      .DEPTH    (DEPTH),
      .FLUSH_CYC(FLUSH_CYC),
      .WRIDX_W  (WRIDX_W),
      .NBYTES_W (NBYTES_W)
    ) u_chan (
      .clk      (i_clk_48MHz),
      .rst      (i_rst),
      .ready    (bus.o_ready[k]),
      .valid    (bus.i_valid[k]),
      .data     (bus.i_data[k*8 +: 8]),
      .flush    (bus.i_flush[k]),
      .et_ready (bus.i_etReady[k]),
      .et_valid (bus.o_etValid[k]),
      .wr_en    (bus.o_etWrEn[k]),
      .wr_idx   (bus.o_etWrIdx[k*WRIDX_W +: WRIDX_W]),
      .wr_byte  (bus.o_etWrByte[k*8 +: 8]),
      .wr_nbytes(bus.o_etWrNBytes[k*NBYTES_W +: NBYTES_W])
    );
  end

endmodule
